adc_oversample_avg: RTL and testbench
=====================================

Name: adc_oversample_avg

Overview:
- Sits between the LTC2315-12 SPI reader and the scan-control stage.
- Qualifies ADC conversions against the current mux address:
  - discards the settling samples that follow every mux address change;
  - averages 2^LOG2_AVG samples and hands one rounded 12-bit result per channel to the downstream valid/ready consumer.
- Removes mux-switching transients and reduces noise before data enters the UART FIFO path.

Parameters:
- DATA_W, 12: ADC sample width.
- ADDR_W, 6: mux address width (channel index).
- SETTLE_N, 4: conversions discarded after an address change (0 allowed).
- LOG2_AVG, 3: log2 of samples averaged per result (1..6).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- smp_data  in  DATA_W  ADC conversion result.
- smp_vld  in  1  one-cycle strobe: smp_data is valid this cycle.
- addr  in  ADDR_W  current mux address from the scan control.
- avg_data  out  DATA_W  averaged result.
- avg_addr  out  ADDR_W  channel address the result belongs to.
- avg_vld  out  1  result valid; held until accepted.
- avg_rdy  in  1  consumer accepts when avg_vld and avg_rdy are both high.
- busy  out  1  high in SETTLE or ACCUM.
- drop_cnt  out  8  saturating count of results lost to backpressure.

Behaviour:
- Reset values:
  - avg_data=0, avg_addr=0, avg_vld=0, busy=0, drop_cnt=0.
  - Accumulator, counters and addr_q are 0; state is IDLE.
- Address tracking: addr is registered into addr_q every cycle. addr_chg = (addr != addr_q), or the first cycle after reset.
- FSM states: IDLE, SETTLE, ACCUM.
  - IDLE: on addr_chg, load settle_cnt=SETTLE_N. Go to SETTLE, or to ACCUM if SETTLE_N==0.
  - SETTLE: each smp_vld decrements settle_cnt. The sample that brings it to 0 is discarded and the FSM moves to ACCUM with acc=0, n=0.
  - ACCUM: each smp_vld does acc += smp_data and n++. Accumulator width is DATA_W+LOG2_AVG+1.
    - When n reaches 2^LOG2_AVG, result = (acc + 2^(LOG2_AVG-1)) >> LOG2_AVG, saturated to 2^DATA_W-1.
    - The result is presented as avg_vld one cycle after the last sample's smp_vld.
    - acc and n are cleared in that same cycle, and the FSM stays in ACCUM: accumulation continues on the same channel without re-settling.
- addr_chg in any state, including the same cycle as smp_vld:
  - aborts the partial accumulation and discards that sample;
  - restarts SETTLE, capturing the new address as the tag.
  - A pending unaccepted result is NOT cleared; it keeps its old avg_addr.
- Output handshake:
  - avg_data and avg_addr are stable while avg_vld=1 and avg_rdy=0.
  - avg_vld drops the cycle after acceptance.
  - If a new result completes while avg_vld=1 and not being accepted that cycle, the new result is dropped and drop_cnt increments, saturating at 255.
  - Acceptance and completion in the same cycle: the new result is loaded and avg_vld stays high, with no drop.
- busy = (state != IDLE). IDLE is reached only out of reset.
- Reset mid-operation: everything clears immediately (asynchronous). The first cycle after reset is treated as addr_chg.

Optional Feature:
- Macro: ADC_TRIM_MINMAX_EN.
- Defined:
  - ACCUM collects 2^LOG2_AVG+2 samples and tracks the running min and max.
  - The result is ((acc - min - max) + 2^(LOG2_AVG-1)) >> LOG2_AVG.
  - The min and max registers reset at each result boundary.
- Undefined: plain mean of 2^LOG2_AVG samples as above; the min/max logic is absent.

Decomposition:
- Shared package adc_pkg holds:
  - DATA_W and ADDR_W defaults;
  - the state enum {IDLE, SETTLE, ACCUM};
  - the function for the rounding shift with saturation.
- One natural sub-module: adc_avg_accum. It holds the accumulator, sample counter and optional min/max, and is driven by clear/add strobes from the FSM.

Test Plan:
- SETTLE_N=4, LOG2_AVG=3: addr 0→5, then 12 smp_vld with data 100..111 → first 4 discarded; avg_data=(104+…+111+4)>>3=108 (exactly 107.5 rounded), avg_addr=5, one cycle after the 12th strobe.
- Constant data 4095 for 8 samples → avg_data=4095 (saturation path, no wrap); constant 0 → 0.
- addr changes after the 5th accumulated sample, with smp_vld in the same cycle → that sample is discarded, no result is emitted for the old channel, and the next result is tagged with the new addr after 4+8 strobes.
- avg_rdy held low across 3 result completions → first result held stable, drop_cnt=2; then avg_rdy=1 for one cycle → avg_vld falls next cycle.
- reset_n asserted mid-ACCUM → all outputs 0 immediately; after release the same addr is re-settled (4 discards) before accumulating.
- ADC_TRIM_MINMAX_EN defined, samples {10,20,20,20,20,20,20,20,20,900} → min and max removed, avg_data=20.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC oversampling averager.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adc_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCUM
  } state_t;

  // Round-half-up divide by 2^sh, clamped to the largest dw-bit value.
  function automatic logic [31:0] round_sat(input logic [31:0] sum,
                                            input int unsigned sh,
                                            input int unsigned dw);
    logic [31:0] r;
    logic [31:0] lim;
    r   = (sum + (32'd1 << (sh - 1))) >> sh;
    lim = (32'd1 << dw) - 32'd1;
    return (r > lim) ? lim : r;
  endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// Sample accumulator: running sum, sample count and (ADC_TRIM_MINMAX_EN) min/max trim.
// Latency: result is combinational on the final add strobe; state clears on that same edge.
// Backpressure: none; the FSM decides whether a finished result is kept or dropped.
module adc_avg_accum
  import adc_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOG2_AVG = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] data,
  output logic              last,
  output logic [DATA_W-1:0] result
);

  localparam int ACC_W = DATA_W + LOG2_AVG + 1;
`ifdef ADC_TRIM_MINMAX_EN
  // Two extra samples so the min and max can be thrown away.
  localparam int N_TOT = (1 << LOG2_AVG) + 2;
`else
  localparam int N_TOT = (1 << LOG2_AVG);
`endif
  localparam int CNT_W = $clog2(N_TOT + 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] sum_fin;
  logic [CNT_W-1:0] n;

  assign acc_nxt = acc + ACC_W'(data);
  assign last    = (n == CNT_W'(N_TOT - 1));

`ifdef ADC_TRIM_MINMAX_EN
  logic [DATA_W-1:0] mn;
  logic [DATA_W-1:0] mx;
  logic [DATA_W-1:0] mn_nxt;
  logic [DATA_W-1:0] mx_nxt;

  // First sample of a block seeds both extremes, so no reset value leaks in.
  assign mn_nxt  = ((n == '0) || (data < mn)) ? data : mn;
  assign mx_nxt  = ((n == '0) || (data > mx)) ? data : mx;
  assign sum_fin = acc_nxt - ACC_W'(mn_nxt) - ACC_W'(mx_nxt);

  // Track running extremes; cleared at every result boundary or abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mn <= '0;
      mx <= '0;
    end else if (clr || (add && last)) begin
      mn <= '0;
      mx <= '0;
    end else if (add) begin
      mn <= mn_nxt;
      mx <= mx_nxt;
    end
  end
`else
  assign sum_fin = acc_nxt;
`endif

  assign result = DATA_W'(round_sat(32'(sum_fin), LOG2_AVG, DATA_W));

  // Sum and count samples; the final sample of a block restarts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      n   <= '0;
    end else if (clr || (add && last)) begin
      acc <= '0;
      n   <= '0;
    end else if (add) begin
      acc <= acc_nxt;
      n   <= n + 1'b1;
    end
  end

endmodule

// File: rtl/adc_oversample_avg.sv
// Qualifies ADC samples per mux address, drops settling samples, emits rounded averages (ADC_TRIM_MINMAX_EN: min/max trimmed).
// Latency: avg_vld rises one cycle after the strobe of the last sample in a block.
// Backpressure: avg_vld/avg_data held until avg_rdy; results finishing while blocked are dropped and counted.
module adc_oversample_avg
  import adc_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SETTLE_N = 4,
  parameter int LOG2_AVG = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              smp_vld,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] avg_data,
  output logic [ADDR_W-1:0] avg_addr,
  output logic              avg_vld,
  input  logic              avg_rdy,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  localparam int SCNT_W = (SETTLE_N < 2) ? 1 : $clog2(SETTLE_N + 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] tag;
  logic              first_q;
  logic [SCNT_W-1:0] settle_cnt;
  logic              addr_chg;
  logic              settle_done;
  logic              acc_clr;
  logic              acc_add;
  logic              acc_last;
  logic              done;
  logic [DATA_W-1:0] acc_result;

  // The first cycle out of reset counts as a channel change so the current
  // address is always settled before any sample is trusted.
  assign addr_chg    = first_q || (addr != addr_q);
  assign settle_done = (state == SETTLE) && smp_vld && (settle_cnt == SCNT_W'(1));
  // Any address change aborts a partial block, including a sample arriving with it.
  assign acc_clr     = addr_chg || settle_done;
  assign acc_add     = (state == ACCUM) && smp_vld && !addr_chg;
  assign done        = acc_add && acc_last;
  assign busy        = (state != IDLE);

  adc_avg_accum #(
    .DATA_W  (DATA_W),
    .LOG2_AVG(LOG2_AVG)
  ) u_accum (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (acc_clr),
    .add    (acc_add),
    .data   (smp_data),
    .last   (acc_last),
    .result (acc_result)
  );

  // Register the mux address every cycle to detect channel changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      first_q <= 1'b1;
    end else begin
      addr_q  <= addr;
      first_q <= 1'b0;
    end
  end

  // Channel state machine: settle after each address change, then accumulate indefinitely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tag        <= '0;
      settle_cnt <= '0;
    end else if (addr_chg) begin
      tag        <= addr;
      settle_cnt <= SCNT_W'(SETTLE_N);
      state      <= (SETTLE_N == 0) ? ACCUM : SETTLE;
    end else begin
      unique case (state)
        SETTLE: begin
          if (smp_vld) begin
            settle_cnt <= settle_cnt - 1'b1;
            if (settle_done) state <= ACCUM;
          end
        end
        default: state <= state;
      endcase
    end
  end

  // Output holding register; a pending result is never overwritten unless it is being taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avg_data <= '0;
      avg_addr <= '0;
      avg_vld  <= 1'b0;
      drop_cnt <= '0;
    end else if (done) begin
      if (!avg_vld || avg_rdy) begin
        avg_data <= acc_result;
        avg_addr <= tag;
        avg_vld  <= 1'b1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (avg_vld && avg_rdy) begin
      avg_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_oversample_avg.sv
// Directed bench for adc_oversample_avg with SETTLE_N=4, LOG2_AVG=3.
// Latency: checks results one cycle after the final strobe of each block.
// Backpressure: exercises hold, drop counting and accept-with-complete.
module tb_adc_oversample_avg;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] smp_data = '0;
  logic              smp_vld = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] avg_data;
  logic [ADDR_W-1:0] avg_addr;
  logic              avg_vld;
  logic              avg_rdy = 1'b1;
  logic              busy;
  logic [7:0]        drop_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] start;
    logic [DATA_W-1:0] step;
    logic [DATA_W-1:0] exp;
  } vec_t;

  vec_t tbl[6];

  always #10 clk = ~clk;

  adc_oversample_avg #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .SETTLE_N(4),
    .LOG2_AVG(3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .smp_data(smp_data),
    .smp_vld (smp_vld),
    .addr    (addr),
    .avg_data(avg_data),
    .avg_addr(avg_addr),
    .avg_vld (avg_vld),
    .avg_rdy (avg_rdy),
    .busy    (busy),
    .drop_cnt(drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle sample strobe; returns just after the capturing edge.
  task automatic strobe(input logic [DATA_W-1:0] d);
    smp_data = d;
    smp_vld  = 1'b1;
    tick();
    smp_vld  = 1'b0;
  endtask

  // cnt strobes of the same value with one idle cycle between them.
  task automatic send_n(input logic [DATA_W-1:0] d, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      if (k > 0) tick();
      strobe(d);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] trim_v[10];

    tbl[0] = '{addr: 6'd5,  start: 12'd100,  step: 12'd1, exp: 12'd108};
    tbl[1] = '{addr: 6'd6,  start: 12'd4095, step: 12'd0, exp: 12'd4095};
    tbl[2] = '{addr: 6'd7,  start: 12'd0,    step: 12'd0, exp: 12'd0};
    tbl[3] = '{addr: 6'd8,  start: 12'd10,   step: 12'd3, exp: 12'd33};
    tbl[4] = '{addr: 6'd9,  start: 12'd1,    step: 12'd0, exp: 12'd1};
    tbl[5] = '{addr: 6'd63, start: 12'd0,    step: 12'd1, exp: 12'd8};

    trim_v = '{12'd10, 12'd20, 12'd20, 12'd20, 12'd20,
               12'd20, 12'd20, 12'd20, 12'd20, 12'd900};

    // Reset values
    #5;
    check("rst_avg_data", avg_data, 0);
    check("rst_avg_addr", avg_addr, 0);
    check("rst_avg_vld", avg_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    tick();
    reset_n = 1'b1;
    check("idle_busy", busy, 0);
    tick();
    check("first_cycle_busy", busy, 1);

`ifdef ADC_TRIM_MINMAX_EN
    addr = 6'd40;
    tick();
    send_n(12'd0, 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      strobe(trim_v[i]);
      if (i == 8) check("trim_early_vld", avg_vld, 0);
    end
    check("trim_vld", avg_vld, 1);
    check("trim_data", avg_data, 20);
    check("trim_addr", avg_addr, 40);
    tick();
`else
    // Table: address change, 4 settling strobes, 8 averaged strobes.
    for (int e = 0; e < 6; e++) begin
      addr = tbl[e].addr;
      tick();
      for (int i = 0; i < 12; i++) begin
        if (i > 0) tick();
        d = tbl[e].start + DATA_W'(i) * tbl[e].step;
        strobe(d);
        if (i == 10) check("tbl_early_vld", avg_vld, 0);
      end
      check("tbl_vld", avg_vld, 1);
      check("tbl_data", avg_data, tbl[e].exp);
      check("tbl_addr", avg_addr, tbl[e].addr);
      check("tbl_busy", busy, 1);
      tick();
      check("tbl_vld_drop", avg_vld, 0);
    end

    // Address change with a coincident sample aborts the partial block.
    addr = 6'd10;
    tick();
    send_n(12'd50, 9);
    tick();
    addr     = 6'd11;
    smp_data = 12'd3000;
    smp_vld  = 1'b1;
    tick();
    smp_vld  = 1'b0;
    check("abort_no_old", avg_vld, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      strobe(12'd200);
      if (i == 10) check("abort_early_vld", avg_vld, 0);
    end
    check("abort_vld", avg_vld, 1);
    check("abort_data", avg_data, 200);
    check("abort_addr", avg_addr, 11);
    tick();

    // Backpressure: three completions while blocked.
    avg_rdy = 1'b0;
    check("drop_init", drop_cnt, 0);
    addr = 6'd20;
    tick();
    send_n(12'd40, 12);
    check("bp_vld", avg_vld, 1);
    check("bp_data", avg_data, 40);
    tick();
    send_n(12'd41, 8);
    check("bp_hold_data", avg_data, 40);
    tick();
    send_n(12'd42, 8);
    check("bp_hold_vld", avg_vld, 1);
    check("bp_hold_data2", avg_data, 40);
    check("bp_hold_addr", avg_addr, 20);
    check("bp_drop_cnt", drop_cnt, 2);
    tick();
    avg_rdy = 1'b1;
    tick();
    avg_rdy = 1'b0;
    check("bp_accept_vld", avg_vld, 0);

    // Acceptance and completion on the same edge.
    tick();
    send_n(12'd50, 8);
    check("sim_first_data", avg_data, 50);
    tick();
    send_n(12'd60, 7);
    tick();
    avg_rdy = 1'b1;
    strobe(12'd60);
    check("sim_vld", avg_vld, 1);
    check("sim_data", avg_data, 60);
    check("sim_drop_cnt", drop_cnt, 2);
    tick();
    check("sim_vld_drop", avg_vld, 0);

    // Asynchronous reset in the middle of accumulation.
    addr = 6'd30;
    tick();
    send_n(12'd5, 6);
    check("mid_busy", busy, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_avg_data", avg_data, 0);
    check("arst_avg_addr", avg_addr, 0);
    check("arst_avg_vld", avg_vld, 0);
    check("arst_busy", busy, 0);
    check("arst_drop_cnt", drop_cnt, 0);
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      strobe((i < 4) ? 12'd999 : 12'd70);
      if (i == 10) check("resettle_early_vld", avg_vld, 0);
    end
    check("resettle_vld", avg_vld, 1);
    check("resettle_data", avg_data, 70);
    check("resettle_addr", avg_addr, 30);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
